// File: rtl/addition.sv
// Registered WIDTH-bit add/subtract/add-with-carry/accumulate unit with flags, 1-cycle latency.
// Optional unsigned saturation of sum when compiled with ADDITION_SATURATE_EN.
module addition #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] neg_b;
    logic             carry_in;
    logic             sign_b;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    assign neg_b = ~B + {{(WIDTH-1){1'b0}}, 1'b1};

    // Subtract runs through the same adder as A + ~B + 1; its sign for overflow is that of -B.
    always_comb begin
        opnd_a   = A;
        opnd_b   = B;
        carry_in = 1'b0;
        sign_b   = B[WIDTH-1];
        case (op)
            OP_ADD: ;
            OP_SUB: begin
                opnd_b   = ~B;
                carry_in = 1'b1;
                sign_b   = neg_b[WIDTH-1];
            end
            OP_ADC: carry_in = carry_out;
            OP_ACC: begin
                opnd_a = sum;
                opnd_b = A;
                sign_b = A[WIDTH-1];
            end
            default: ;
        endcase

        raw      = {1'b0, opnd_a} + {1'b0, opnd_b} + {{WIDTH{1'b0}}, carry_in};
        ovf_next = (opnd_a[WIDTH-1] == sign_b) && (raw[WIDTH-1] != opnd_a[WIDTH-1]);
        sum_next = raw[WIDTH-1:0];
`ifdef ADDITION_SATURATE_EN
        // Flags still describe the unclamped result; only sum/zero see the clamp.
        if (op == OP_SUB) begin
            if (!raw[WIDTH]) sum_next = '0;
        end else if (raw[WIDTH]) begin
            sum_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= sum_next;
                carry_out <= raw[WIDTH];
                overflow  <= ovf_next;
                zero      <= (sum_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_addition.sv
// Scoreboard bench for addition: integer reference model pushes expectations at acceptance,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_addition;
    localparam int W    = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] sum;
    logic         carry_out, overflow, zero, out_valid;

    addition #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .op(op),
        .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int c;
        int v;
        int z;
    } exp_t;

    exp_t exp_q[$];
    exp_t hold;
    int   total = 0;
    int   bad   = 0;
    int   m_sum = 0;
    int   m_carry = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= HALF) ? 1 : 0;
    endfunction

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input int o, input int a, input int b);
        exp_t e;
        int x, y, r, full;
        x = a; y = b;
        case (o)
            0: full = a + b;
            1: begin y = (MOD - b) % MOD; full = a + (MOD - b); end
            2: full = a + b + m_carry;
            default: begin x = m_sum; y = a; full = m_sum + a; end
        endcase
        if (o == 1) e.c = (a >= b) ? 1 : 0;
        else        e.c = (full >= MOD) ? 1 : 0;
        r   = full % MOD;
        e.v = (sgn(x) == sgn(y) && sgn(r) != sgn(x)) ? 1 : 0;
        m_sum   = r;
        m_carry = e.c;
`ifdef ADDITION_SATURATE_EN
        if (o == 1 && e.c == 0) r = 0;
        else if (o != 1 && e.c == 1) r = MOD - 1;
        m_sum = r;
`endif
        e.s = r;
        e.z = (r == 0) ? 1 : 0;
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst_n && in_valid) exp_q.push_back(model(int'(op), int'(A), int'(B)));
    end

    always @(negedge rst_n) begin
        exp_q.delete();
        m_sum = 0;
        m_carry = 0;
        hold = '{0, 0, 0, 1};
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            hold = exp_q.pop_front();
            chk("out_valid", int'(out_valid), 1);
        end else begin
            chk("out_valid_idle", int'(out_valid), 0);
        end
        chk("sum", int'(sum), hold.s);
        chk("carry_out", int'(carry_out), hold.c);
        chk("overflow", int'(overflow), hold.v);
        chk("zero", int'(zero), hold.z);
    end

    task automatic drive(input logic v, input int a, input int b, input int o);
        @(posedge clk);
        #1;
        in_valid = v;
        A  = W'(a);
        B  = W'(b);
        op = 2'(o);
    endtask

    initial begin
        hold = '{0, 0, 0, 1};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sum", int'(sum), 0);
        chk("reset_zero", int'(zero), 1);
        chk("reset_valid", int'(out_valid), 0);
        rst_n = 1'b1;

        // add 0101+0011
        drive(1, 5, 3, 0);
        drive(0, 9, 9, 0);
`ifdef ADDITION_SATURATE_EN
        chk("d_add_sum", int'(sum), 8);
`else
        chk("d_add_sum", int'(sum), 4'b1000);
`endif
        chk("d_add_ovf", int'(overflow), 1);
        chk("d_add_cy", int'(carry_out), 0);

        // consecutive adds
        drive(1, 4'b1010, 4'b0010, 0);
        drive(1, 4'b0010, 4'b0111, 0);
        drive(0, 3, 3, 0);

        // carry then add-with-carry
        drive(1, 4'b1111, 4'b0001, 0);
        drive(0, 1, 1, 1);
`ifdef ADDITION_SATURATE_EN
        chk("d_cy_sum", int'(sum), 4'b1111);
`else
        chk("d_cy_sum", int'(sum), 4'b0000);
`endif
        chk("d_cy_cy", int'(carry_out), 1);
        drive(1, 0, 0, 2);
        drive(0, 5, 6, 3);

        // subtract with borrow
        drive(1, 4'b0011, 4'b0101, 1);
        drive(0, 0, 0, 0);
`ifdef ADDITION_SATURATE_EN
        chk("d_sub_sum", int'(sum), 0);
`else
        chk("d_sub_sum", int'(sum), 4'b1110);
`endif
        chk("d_sub_cy", int'(carry_out), 0);

        // idle with changing inputs
        for (int i = 0; i < 5; i++) drive(0, $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1), i % 4);

        // accumulate after reset, then asynchronous reset between edges
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1, 3, 9, 3);
        drive(0, 0, 0, 0);
        chk("d_acc_sum", int'(sum), 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sum", int'(sum), 0);
        chk("async_zero", int'(zero), 1);
        chk("async_valid", int'(out_valid), 0);
        chk("async_cy", int'(carry_out), 0);
        drive(1, 7, 7, 0);
        drive(0, 0, 0, 0);
        #2 rst_n = 1'b1;
        drive(1, 3, 0, 3);
        drive(0, 0, 0, 0);
        chk("acc_after_rst", int'(sum), 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, MOD - 1),
                  $urandom_range(0, MOD - 1), $urandom_range(0, 3));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/addition.md
ADDITION -- requirements
Module: addition

Interface
REQ-001 Parameter WIDTH, default 4, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operands and op valid this cycle.
REQ-005 A  input  WIDTH  first operand.
REQ-006 B  input  WIDTH  second operand.
REQ-007 op  input  2  00 add, 01 subtract (A-B), 10 add with carry-in from stored carry, 11 accumulate (sum+A).
REQ-008 sum  output  WIDTH  registered result.
REQ-009 carry_out  output  1  registered unsigned carry (add) or no-borrow (subtract, 1 when A>=B).
REQ-010 overflow  output  1  registered two's-complement signed overflow.
REQ-011 zero  output  1  registered, 1 when sum is all zeros.
REQ-012 out_valid  output  1  registered, 1 for one cycle per accepted input.

Function
REQ-013 Operands SHALL be accepted on every rising clk edge where in_valid=1; no backpressure exists.
REQ-014 Latency SHALL be exactly 1 cycle: results appear on the edge after acceptance, and out_valid SHALL equal in_valid delayed by one cycle.
REQ-015 When in_valid=0, sum, carry_out, overflow and zero SHALL hold their previous values.
REQ-016 Add: {carry_out,sum} = A+B computed at WIDTH+1 bits; sum takes the low WIDTH bits (wrap-around modulo 2^WIDTH).
REQ-017 Subtract: sum = A + ~B + 1 modulo 2^WIDTH; carry_out = carry of that sum.
REQ-018 Add-with-carry: {carry_out,sum} = A+B+stored carry_out.
REQ-019 Accumulate: {carry_out,sum} = current sum register + A; B ignored.
REQ-020 overflow SHALL be 1 when both effective operands share a sign bit and the result sign differs (effective second operand is ~B+1 for subtract).
REQ-021 zero SHALL reflect the value written into sum on the same edge.
REQ-022 Back-to-back valid inputs SHALL produce back-to-back results, each using the state left by the previous one (carry, accumulator).

Reset
REQ-023 On rst_n=0 sum, carry_out, overflow and out_valid SHALL clear to 0 and zero SHALL set to 1, immediately and independent of clk.
REQ-024 An input accepted on the edge where reset is asserted SHALL be discarded; after rst_n rises, the first accepted input starts from cleared carry and accumulator.

Configuration
REQ-025 Macro ADDITION_SATURATE_EN SHALL compile in unsigned saturation.
REQ-026 With ADDITION_SATURATE_EN defined: add, add-with-carry and accumulate results that carry out SHALL clamp sum to all ones; subtract results that borrow SHALL clamp sum to 0; carry_out and overflow report the unclamped arithmetic.
REQ-027 Without ADDITION_SATURATE_EN the block SHALL wrap modulo 2^WIDTH per REQ-016..REQ-019 and contain no saturation logic.

Verification (WIDTH=4, macro undefined unless stated)
REQ-028 Add A=0101, B=0011, in_valid=1 -> next cycle sum=1000, carry_out=0, overflow=1, zero=0, out_valid=1.
REQ-029 Add A=1010, B=0010 -> sum=1100, carry_out=0, overflow=0; then add A=0010, B=0111 -> sum=1001, overflow=1, on consecutive cycles.
REQ-030 Add A=1111, B=0001 -> sum=0000, carry_out=1, zero=1; then op=10 with A=0000, B=0000 -> sum=0001; repeat with ADDITION_SATURATE_EN defined -> first result sum=1111, carry_out=1.
REQ-031 Subtract A=0011, B=0101 -> sum=1110, carry_out=0; with ADDITION_SATURATE_EN -> sum=0000.
REQ-032 Accumulate A=0011 three times from reset -> sum 0011, 0110, 1001; assert rst_n=0 mid-sequence between clock edges -> all outputs clear immediately, zero=1, out_valid=0.
REQ-033 in_valid=0 for several cycles with changing A/B -> sum/flags unchanged, out_valid=0.
